// File: rtl/pws_pkg.sv
// Shared definitions for the pulse-width scaler: FSM encodings and width helpers.
package pws_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HOLD = 3'd1;
  localparam logic [2:0] ST_MUL  = 3'd2;
  localparam logic [2:0] ST_DIV  = 3'd3;
  localparam logic [2:0] ST_ADD  = 3'd4;
  localparam logic [2:0] ST_SEND = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Channel index width; a single channel still gets a 1-bit ch_out.
  function automatic int ch_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int prod_w(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/pws_seq_divider.sv
// Restoring divider: one quotient bit per cycle, W iterations, done pulses when the quotient is final.
module pws_seq_divider #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W:0]    trial;

  // q_q shifts dividend bits out the top while quotient bits enter at the bottom.
  always_comb begin
    rem_d  = rem_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = {rem_q, q_q[W-1]};
    if (start) begin
      rem_d  = '0;
      q_d    = dividend;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, divisor}) begin
        rem_d = W'(trial - {1'b0, divisor});
        q_d   = {q_q[W-2:0], 1'b1};
      end else begin
        rem_d = trial[W-1:0];
        q_d   = {q_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = q_q;

endmodule

// File: rtl/pulse_width_scaler_mc.sv
// Multi-channel pulse-width scaler: round-robin grant, then Y = NUMERATOR*X/DENOMINATOR + OFFSET
// through a shared multiplier and sequential divider, delivered over a 4-phase handshake.
module pulse_width_scaler_mc
  import pws_pkg::*;
#(
  parameter int               CH          = 2,
  parameter int               IN_W        = 8,
  parameter int               OUT_W       = 32,
  parameter logic [OUT_W-1:0] NUMERATOR   = 'hABE0,
  parameter logic [OUT_W-1:0] DENOMINATOR = 'hFF,
  parameter logic [OUT_W-1:0] OFFSET      = 'hD0FC,
  parameter bit               SATURATE    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         rdy_in,
  input  logic [CH*IN_W-1:0]    request,
  output logic [CH-1:0]         akn_out,
  output logic                  rdy_out,
  input  logic                  akn_in,
  output logic [OUT_W-1:0]      time_output,
  output logic [ch_w(CH)-1:0]   ch_out,
  output logic                  sat_out
);

  localparam int CW     = ch_w(CH);
  localparam int PROD_W = prod_w(IN_W, OUT_W);
  localparam logic [PROD_W:0] MAX_OUT = {{(PROD_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  if (DENOMINATOR == '0) begin : g_bad_denom
    $error("pulse_width_scaler_mc: DENOMINATOR must be nonzero");
  end
  if (CH < 1 || CH > 8) begin : g_bad_ch
    $error("pulse_width_scaler_mc: CH must be 1..8");
  end

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [IN_W-1:0]   data_q, data_d;
  logic [CH-1:0]     akn_q, akn_d;
  logic              rdy_q, rdy_d;
  logic              sat_q, sat_d;
  logic [OUT_W-1:0]  time_q, time_d;

  logic              gnt_vld;
  logic [CW-1:0]     gnt_idx;
  logic [IN_W-1:0]   gnt_data;
  logic              sel_rdy;
  logic [PROD_W-1:0] product, quotient;
  logic [PROD_W:0]   sum;
  logic              div_start, div_busy, div_done;

  // Walk downward so the lowest index at or after the pointer is the last (winning) assignment.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    sel_rdy  = 1'b0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (rdy_in[wrap_add(int'(ptr_q), k, CH)]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(wrap_add(int'(ptr_q), k, CH));
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (gnt_idx == CW'(i)) gnt_data = request[i*IN_W +: IN_W];
      if (ch_q == CW'(i))    sel_rdy  = rdy_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_vld) state_d = ST_HOLD;
      ST_HOLD: if (!sel_rdy) state_d = ST_MUL;
      ST_MUL:  state_d = ST_DIV;
      ST_DIV:  if (div_done && !div_busy) state_d = ST_ADD;
      ST_ADD:  state_d = ST_SEND;
      ST_SEND: if (akn_in) state_d = ST_DONE;
      ST_DONE: if (!akn_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    data_d    = data_q;
    akn_d     = akn_q;
    rdy_d     = rdy_q;
    sat_d     = sat_q;
    time_d    = time_q;
    div_start = 1'b0;
    product   = {{IN_W{1'b0}}, NUMERATOR} * {{OUT_W{1'b0}}, data_q};
    sum       = {1'b0, quotient} + {{(PROD_W + 1 - OUT_W){1'b0}}, OFFSET};
    case (state_q)
      ST_IDLE: if (gnt_vld) begin
        data_d = gnt_data;
        ch_d   = gnt_idx;
        for (int i = 0; i < CH; i++) akn_d[i] = (gnt_idx == CW'(i));
        time_d = '0;
        sat_d  = 1'b0;
        ptr_d  = CW'(wrap_add(int'(gnt_idx), 1, CH));
      end
      ST_HOLD: if (!sel_rdy) akn_d = '0;
      // Divider captures the product on the same edge the FSM moves to DIV.
      ST_MUL:  div_start = 1'b1;
      ST_ADD: begin
        rdy_d = 1'b1;
        if (sum > MAX_OUT) begin
          sat_d  = 1'b1;
          time_d = SATURATE ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
        end else begin
          time_d = sum[OUT_W-1:0];
        end
      end
      ST_SEND: if (akn_in) rdy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      ch_q   <= '0;
      data_q <= '0;
      akn_q  <= '0;
      rdy_q  <= 1'b0;
      sat_q  <= 1'b0;
      time_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      ch_q   <= ch_d;
      data_q <= data_d;
      akn_q  <= akn_d;
      rdy_q  <= rdy_d;
      sat_q  <= sat_d;
      time_q <= time_d;
    end
  end

  pws_seq_divider #(.W(PROD_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (product),
    .divisor  ({{IN_W{1'b0}}, DENOMINATOR}),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  assign akn_out     = akn_q;
  assign rdy_out     = rdy_q;
  assign time_output = time_q;
  assign ch_out      = ch_q;
  assign sat_out     = sat_q;

endmodule

// File: tb/tb_pulse_width_scaler_mc.sv
// Bench for pulse_width_scaler_mc: vector table, RR/reset/backpressure sequences, random requests vs a reference model.
`timescale 1ns/1ps
module tb_pulse_width_scaler_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rdy_in;
  logic [15:0] request;
  logic [1:0]  akn_out;
  logic        rdy_out, akn_in, sat_out;
  logic [31:0] time_output;
  logic [0:0]  ch_out;

  logic [0:0]  rdy16, akn_s, akn_t, cho_s, cho_t;
  logic [7:0]  req16;
  logic        akn_in16, rdyo_s, rdyo_t, sat_s, sat_t;
  logic [15:0] tim_s, tim_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_width_scaler_mc #(.CH(2)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .request(request), .akn_out(akn_out),
    .rdy_out(rdy_out), .akn_in(akn_in), .time_output(time_output), .ch_out(ch_out), .sat_out(sat_out)
  );

  pulse_width_scaler_mc #(.CH(1), .IN_W(8), .OUT_W(16), .NUMERATOR(16'hABE0), .DENOMINATOR(16'hFF),
                          .OFFSET(16'hD0FC), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .rdy_in(rdy16), .request(req16), .akn_out(akn_s),
    .rdy_out(rdyo_s), .akn_in(akn_in16), .time_output(tim_s), .ch_out(cho_s), .sat_out(sat_s)
  );

  pulse_width_scaler_mc #(.CH(1), .IN_W(8), .OUT_W(16), .NUMERATOR(16'hABE0), .DENOMINATOR(16'hFF),
                          .OFFSET(16'hD0FC), .SATURATE(1'b0)) u_trn (
    .clk(clk), .rst(rst), .rdy_in(rdy16), .request(req16), .akn_out(akn_t),
    .rdy_out(rdyo_t), .akn_in(akn_in16), .time_output(tim_t), .ch_out(cho_t), .sat_out(sat_t)
  );

  typedef struct {
    int          ch;
    logic [7:0]  d;
    logic [31:0] t;
    logic        s;
  } vec_t;

  // Returns {overflow, time}: plain integer arithmetic on the scaling formula.
  function automatic logic [32:0] ref_y(input longint x, input longint num, input longint den,
                                        input longint off, input int ow, input bit satur);
    longint s, mx;
    s  = (num * x) / den + off;
    mx = (longint'(1) << ow) - 1;
    if (s > mx) return {1'b1, satur ? 32'(mx) : 32'(s & mx)};
    return {1'b0, 32'(s)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int g);
    int n;
    n = 0;
    g = -1;
    while (akn_out == 2'b00 && n < 60) begin
      tick();
      n++;
    end
    if (akn_out == 2'b01) g = 0;
    else if (akn_out == 2'b10) g = 1;
    chk("grant_onehot", 64'(g >= 0), 64'd1);
  endtask

  // Requester drops rdy_in, sink collects the result; hold keeps akn_in high for extra cycles.
  task automatic collect(input int g, input int hold, output logic [31:0] got_t, output logic got_s);
    int n, lat;
    logic [32:0] e;
    e = ref_y(longint'(request[g*8 +: 8]), 'hABE0, 'hFF, 'hD0FC, 32, 1'b1);
    rdy_in[g] = 1'b0;
    n = 0;
    while (akn_out[g] && n < 10) begin
      tick();
      n++;
    end
    chk("akn_release", 64'(akn_out[g]), 64'd0);
    lat = 0;
    while (!rdy_out && lat < 100) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'd43);
    chk("time_output", 64'(time_output), 64'(e[31:0]));
    chk("sat_out", 64'(sat_out), 64'(e[32]));
    chk("ch_out", 64'(ch_out), 64'(g));
    got_t = time_output;
    got_s = sat_out;
    akn_in = 1'b1;
    tick();
    chk("rdy_drop", 64'(rdy_out), 64'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("akn_blocked", 64'(akn_out), 64'd0);
    end
    akn_in = 1'b0;
    tick();
  endtask

  initial begin
    vec_t        tv[5];
    int          g, n, c;
    logic [31:0] gt;
    logic        gs;
    logic [32:0] e;
    logic [7:0]  d;

    tv[0] = '{0, 8'hFF, 32'h17CDC, 1'b0};
    tv[1] = '{0, 8'h00, 32'h0D0FC, 1'b0};
    tv[2] = '{1, 8'h80, 32'h12742, 1'b0};
    tv[3] = '{1, 8'h01, 32'h0D1A8, 1'b0};
    tv[4] = '{0, 8'h40, 32'h0FC1F, 1'b0};

    rst = 1'b1; rdy_in = '0; request = '0; akn_in = 1'b0;
    rdy16 = '0; req16 = '0; akn_in16 = 1'b0;
    #1;
    chk("reset_outputs", {akn_out, rdy_out, sat_out, ch_out, time_output}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Simultaneous requests from a fresh pointer, then a re-asserting ch0 behind pending ch1.
    request = {8'h20, 8'h10};
    rdy_in  = 2'b11;
    wait_grant(g);
    chk("rr_first", 64'(g), 64'd0);
    if (g >= 0) collect(g, 0, gt, gs);
    request[7:0] = 8'h30;
    rdy_in[0] = 1'b1;
    wait_grant(g);
    chk("rr_second", 64'(g), 64'd1);
    if (g >= 0) collect(g, 0, gt, gs);
    wait_grant(g);
    chk("rr_third", 64'(g), 64'd0);
    if (g >= 0) collect(g, 0, gt, gs);

    foreach (tv[i]) begin
      request[tv[i].ch*8 +: 8] = tv[i].d;
      rdy_in[tv[i].ch] = 1'b1;
      wait_grant(g);
      chk("vec_grant", 64'(g), 64'(tv[i].ch));
      if (g >= 0) begin
        collect(g, 0, gt, gs);
        chk("vec_time", 64'(gt), 64'(tv[i].t));
        chk("vec_sat", 64'(gs), 64'(tv[i].s));
      end
      rdy_in = '0;
    end

    // Stuck sink with ch1 waiting; ch1 then holds its request across HOLD.
    request = {8'h20, 8'h10};
    rdy_in[0] = 1'b1;
    wait_grant(g);
    chk("bp_grant0", 64'(g), 64'd0);
    rdy_in[1] = 1'b1;
    if (g >= 0) collect(g, 10, gt, gs);
    wait_grant(g);
    chk("bp_grant1", 64'(g), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("akn_hold", 64'(akn_out), 64'd2);
    end
    if (g >= 0) collect(g, 0, gt, gs);
    rdy_in = '0;

    // Reset while dividing, with ch0 re-requesting.
    request[7:0] = 8'hFF;
    rdy_in[0] = 1'b1;
    wait_grant(g);
    rdy_in[0] = 1'b0;
    n = 0;
    while (akn_out[0] && n < 10) begin
      tick();
      n++;
    end
    repeat (10) tick();
    rdy_in[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {akn_out, rdy_out, sat_out, ch_out, time_output}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("no_stale_rdy", 64'(rdy_out), 64'd0);
    wait_grant(g);
    chk("rst_regrant", 64'(g), 64'd0);
    if (g >= 0) collect(g, 0, gt, gs);
    chk("rst_result", 64'(gt), 64'h17CDC);

    // 16-bit output variants, saturating and truncating.
    req16 = 8'hFF;
    rdy16 = 1'b1;
    n = 0;
    while (!(akn_s[0] && akn_t[0]) && n < 20) begin
      tick();
      n++;
    end
    rdy16 = 1'b0;
    n = 0;
    while (!(rdyo_s && rdyo_t) && n < 100) begin
      tick();
      n++;
    end
    e = ref_y(255, 'hABE0, 'hFF, 'hD0FC, 16, 1'b1);
    chk("sat16_time", 64'(tim_s), 64'(e[31:0]));
    chk("sat16_flag", 64'(sat_s), 64'(e[32]));
    chk("sat16_const", 64'(tim_s), 64'hFFFF);
    e = ref_y(255, 'hABE0, 'hFF, 'hD0FC, 16, 1'b0);
    chk("trn16_time", 64'(tim_t), 64'(e[31:0]));
    chk("trn16_flag", 64'(sat_t), 64'(e[32]));
    chk("trn16_const", 64'(tim_t), 64'h7CDC);
    akn_in16 = 1'b1;
    tick();
    tick();
    akn_in16 = 1'b0;
    tick();

    for (int it = 0; it < 16; it++) begin
      c = int'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      request[c*8 +: 8] = d;
      rdy_in[c] = 1'b1;
      wait_grant(g);
      chk("rand_grant", 64'(g), 64'(c));
      if (g >= 0) collect(g, 0, gt, gs);
      rdy_in = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
